// File: rtl/ram_sp_if.sv
// Request/response signal bundle for the parametrised single-port RAM.
// parity_err exists only when RAM_PARITY_EN is defined.
interface ram_sp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  localparam int NUM_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH-1:0] address;
  logic                  write_enb;
  logic                  read_enb;
  logic [NUM_BYTES-1:0]  byte_enb;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  busy;
`ifdef RAM_PARITY_EN
  logic                  parity_err;
`endif

  modport master (
    output data_in, address, write_enb, read_enb, byte_enb,
`ifdef RAM_PARITY_EN
    input  parity_err,
`endif
    input  data_out, data_valid, busy
  );

  modport slave (
    input  data_in, address, write_enb, read_enb, byte_enb,
`ifdef RAM_PARITY_EN
    output parity_err,
`endif
    output data_out, data_valid, busy
  );
endinterface

// File: rtl/ram_sp_param.sv
// Parametrised single-port RAM: byte-masked writes, pipelined reads with a
// data_valid strobe, optional post-reset clear, optional parity (RAM_PARITY_EN).
module ram_sp_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int RD_LATENCY = 1,
  parameter int INIT_CLEAR = 1
) (
  input logic   clk,
  input logic   reset,
  ram_sp_if.slave bus
);
  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int NUM_BYTES = DATA_WIDTH / 8;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  localparam state_t RST_STATE = (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

  logic [NUM_BYTES-1:0]  wr_mask;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_fire;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] pipe_data [RD_LATENCY];
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  data_valid_q;

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RST_STATE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (&clr_addr_q) state_d = ST_READY;
      end
      default: ;
    endcase
  end

  assign bus.busy = (state_q == ST_CLEAR);

  // ---------------------------------------------------------------------------
  // Write port: the clear sequencer owns the array while it runs; a write
  // request always beats a simultaneous read request.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_mask = '0;
    wr_addr = bus.address;
    wr_data = bus.data_in;
    if (reset) begin
      if (state_q == ST_CLEAR) begin
        wr_mask = '1;
        wr_addr = clr_addr_q;
        wr_data = '0;
      end else if (bus.write_enb) begin
        wr_mask = bus.byte_enb;
      end
    end
  end

  assign rd_fire = (state_q == ST_READY) && bus.read_enb && !bus.write_enb;

  // NOTE: the storage array has no reset; clearing it is the sequencer's job,
  // and a reset branch here would turn the RAM into a flop bank.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (wr_mask[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

`ifdef RAM_PARITY_EN
  logic [NUM_BYTES-1:0] par_mem [DEPTH];
  logic                 pipe_perr [RD_LATENCY];
  logic                 parity_err_q;

  function automatic logic [NUM_BYTES-1:0] byte_parity(input logic [DATA_WIDTH-1:0] w);
    logic [NUM_BYTES-1:0] p;
    p = '0;
    for (int i = 0; i < NUM_BYTES; i++) p[i] = ^w[8*i +: 8];
    return p;
  endfunction

  // Even parity per byte; untouched bytes keep their existing parity bit.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (wr_mask[i]) par_mem[wr_addr][i] <= ^wr_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rd_fire)
      pipe_perr[0] <= |(par_mem[bus.address] ^ byte_parity(mem[bus.address]));
    for (int k = 1; k < RD_LATENCY; k++) pipe_perr[k] <= pipe_perr[k-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) parity_err_q <= 1'b0;
    else        parity_err_q <= pipe_vld[RD_LATENCY-1] && pipe_perr[RD_LATENCY-1];
  end

  assign bus.parity_err = parity_err_q;
`endif

  // ---------------------------------------------------------------------------
  // Read pipeline: data is captured on the request edge, then shifted so the
  // result appears RD_LATENCY edges later.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rd_fire) pipe_data[0] <= mem[bus.address];
    for (int k = 1; k < RD_LATENCY; k++) pipe_data[k] <= pipe_data[k-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_vld     <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      pipe_vld[0] <= rd_fire;
      for (int k = 1; k < RD_LATENCY; k++) pipe_vld[k] <= pipe_vld[k-1];
      data_valid_q <= pipe_vld[RD_LATENCY-1];
      // data_out holds the last result between reads.
      if (pipe_vld[RD_LATENCY-1]) data_out_q <= pipe_data[RD_LATENCY-1];
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;

endmodule

// File: tb/tb_ram_sp_param.sv
// Scoreboard bench for ram_sp_param: a word-array reference model predicts
// read results and timing; a negedge monitor compares what the DUT presents.
module tb_ram_sp_param;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int LAT   = 2;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst_n;

  ram_sp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
  ram_sp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

  ram_sp_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT), .INIT_CLEAR(1)) dut_a (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_a)
  );

  ram_sp_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(4), .INIT_CLEAR(0)) dut_b (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_b)
  );

  int          checks;
  int          errors;
  int          edge_n;
  int          clr_left;
  bit          mon_en;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] last_data;
  exp_t        sb [$];
  exp_t        mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // One clock edge of stimulus on bus_a; the model applies the request rules.
  task automatic step(input bit we, input bit re, input logic [AW-1:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    bus_a.write_enb = we;
    bus_a.read_enb  = re;
    bus_a.address   = a;
    bus_a.data_in   = d;
    bus_a.byte_enb  = be;
    @(posedge clk);
    edge_n++;
    if (rst_n) begin
      if (clr_left > 0) begin
        clr_left--;
      end else if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) model_mem[a][8*i +: 8] = d[8*i +: 8];
      end else if (re) begin
        sb.push_back('{edge_n + LAT, model_mem[a]});
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0);
  endtask

  // Called just after a negedge; returns at a negedge with reset released.
  task automatic apply_reset(input int hold);
    #1 rst_n = 1'b0;
    clr_left  = DEPTH;
    sb.delete();
    last_data = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    #1;
    check("rst_data_out", bus_a.data_out, 32'h0);
    check("rst_data_valid", bus_a.data_valid, 1'b0);
    check("rst_busy", bus_a.busy, 1'b1);
    check("rst_busy_b", bus_b.busy, 1'b0);
    mon_en = 1'b1;
    idle(hold);
    rst_n = 1'b1;
  endtask

  task automatic measure_clear();
    int n;
    n = 0;
    while (bus_a.busy && n < 100) begin
      idle(1);
      n++;
    end
    check("clear_length", n, DEPTH);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy_a", bus_a.busy, (clr_left > 0) || !rst_n);
      check("busy_b", bus_b.busy, 1'b0);
      if (bus_a.data_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 1'b1, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          check("rd_cycle", edge_n, mon_e.due);
          check("rd_data", bus_a.data_out, mon_e.data);
          last_data = mon_e.data;
`ifdef RAM_PARITY_EN
          check("parity_err_a", bus_a.parity_err, 1'b0);
`endif
        end
      end else begin
        check("data_hold", bus_a.data_out, last_data);
        if (sb.size() > 0 && sb[0].due <= edge_n) begin
          check("missing_valid", 1'b0, 1'b1);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0; edge_n = 0; clr_left = 0; mon_en = 1'b0;
    last_data = '0;
    rst_n = 1'b1;
    bus_a.write_enb = 1'b0; bus_a.read_enb = 1'b0; bus_a.address = '0;
    bus_a.data_in = '0; bus_a.byte_enb = '0;
    bus_b.write_enb = 1'b0; bus_b.read_enb = 1'b0; bus_b.address = '0;
    bus_b.data_in = '0; bus_b.byte_enb = '0;

    @(negedge clk);
    apply_reset(2);

    // Write during the clear is lost; busy lasts one edge per word.
    step(1'b1, 1'b0, 4'd5, 32'h5555_5555, 4'hF);
    begin : clear_count
      int n;
      n = 1;
      while (bus_a.busy && n < 100) begin
        idle(1);
        n++;
      end
      check("clear_length", n, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, AW'(i), '0, '0);
    idle(4);

    // Pipelined back-to-back reads.
    step(1'b1, 1'b0, 4'd3, 32'hDEAD_BEEF, 4'hF);
    step(1'b1, 1'b0, 4'd4, 32'h1234_5678, 4'hF);
    step(1'b0, 1'b1, 4'd3, '0, '0);
    step(1'b0, 1'b1, 4'd4, '0, '0);
    idle(4);

    // Byte mask, including an all-zero mask no-op.
    step(1'b1, 1'b0, 4'd5, 32'hAABB_CCDD, 4'hF);
    step(1'b1, 1'b0, 4'd5, 32'h1122_3344, 4'b0101);
    step(1'b0, 1'b1, 4'd5, '0, '0);
    step(1'b1, 1'b0, 4'd5, 32'hFFFF_FFFF, 4'b0000);
    step(1'b0, 1'b1, 4'd5, '0, '0);
    idle(4);

    // Collision: write wins, read dropped; follow-up read sees new data.
    step(1'b1, 1'b1, 4'd7, 32'h0000_00FF, 4'hF);
    idle(3);
    step(1'b0, 1'b1, 4'd7, '0, '0);
    idle(4);

    // Randomised traffic.
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           AW'($urandom), $urandom, 4'($urandom));
    idle(4);

    // Reset with a read in flight: nothing comes out, clear restarts at 0.
    step(1'b0, 1'b1, 4'd2, '0, '0);
    idle(1);
    apply_reset(1);
    measure_clear();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, AW'(i), '0, '0);
    idle(4);

    // Second instance: latency 4, no clear.
    bus_b.write_enb = 1'b1; bus_b.address = 4'd9;
    bus_b.data_in = 32'hCAFE_F00D; bus_b.byte_enb = 4'hF;
    idle(1);
    bus_b.write_enb = 1'b0;
`ifdef RAM_PARITY_EN
    dut_b.par_mem[9][0] = ~dut_b.par_mem[9][0];
`endif
    bus_b.read_enb = 1'b1;
    idle(1);
    bus_b.read_enb = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      idle(1);
      check($sformatf("lat4_valid_%0d", k), bus_b.data_valid, k == 4);
      if (k == 4) begin
        check("lat4_data", bus_b.data_out, 32'hCAFE_F00D);
`ifdef RAM_PARITY_EN
        check("lat4_parity_err", bus_b.parity_err, 1'b1);
`endif
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
